// File: rtl/cpu_pkg.sv
// Shared opcodes, FSM states, instruction classes and ALU/skip encodings
// for the accumulator CPU controller.
package cpu_pkg;

  localparam logic [3:0] OP_ADD   = 4'h0;
  localparam logic [3:0] OP_HALT  = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_CLEAR = 4'h4;
  localparam logic [3:0] OP_SKIP  = 4'h5;
  localparam logic [3:0] OP_JUMP  = 4'h6;
  localparam logic [3:0] OP_ADDI  = 4'h7;

  localparam logic [3:0] ALU_ADD = 4'b0010;

  localparam logic [2:0] SK_ZERO = 3'b010;
  localparam logic [2:0] SK_NEG  = 3'b000;
  localparam logic [2:0] SK_POS  = 3'b100;

  typedef enum logic [3:0] {
    IDLE, F0, F1, F2, D, M0, M1, M2, X, S0, HALTED
  } state_t;

  // What the decode state does next; CL_NOP covers the illegal opcodes.
  typedef enum logic [2:0] {
    CL_MEM, CL_STORE, CL_CLEAR, CL_SKIP, CL_JUMP, CL_ADDI, CL_HALT, CL_NOP
  } iclass_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: class, skip condition, ADDI immediate
// and illegal-opcode flag.
module ctrl_decode import cpu_pkg::*; #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] ir,
  input  logic [DATA_WIDTH-1:0] ac,
  output iclass_t               iclass,
  output logic                  skip_taken,
  output logic [DATA_WIDTH-1:0] imm_sext,
  output logic                  illegal
);

  logic [3:0] op;
  logic       ac_neg, ac_zero, cond;
  logic       unused_ir;

  assign op        = ir[DATA_WIDTH-1 -: 4];
  assign ac_neg    = ac[DATA_WIDTH-1];
  assign ac_zero   = (ac == '0);
  assign illegal   = op[3];
  assign imm_sext  = {{(DATA_WIDTH-8){ir[27]}}, ir[27:20]};
  assign unused_ir = ^ir[19:3];

  always_comb begin
    iclass = CL_NOP;
    case (op)
      OP_ADD, OP_LOAD: iclass = CL_MEM;
      OP_STORE:        iclass = CL_STORE;
      OP_CLEAR:        iclass = CL_CLEAR;
      OP_SKIP:         iclass = CL_SKIP;
      OP_JUMP:         iclass = CL_JUMP;
      OP_ADDI:         iclass = CL_ADDI;
      OP_HALT:         iclass = CL_HALT;
      default:         iclass = CL_NOP;
    endcase
  end

  // Unlisted skip codes never skip.
  always_comb begin
    cond = 1'b0;
    case (ir[2:0])
      SK_ZERO: cond = ac_zero;
      SK_NEG:  cond = ac_neg;
      SK_POS:  cond = !ac_neg && !ac_zero;
      default: cond = 1'b0;
    endcase
  end

  assign skip_taken = (op == OP_SKIP) && cond;

endmodule

// File: rtl/acc_cpu_controller.sv
// Fetch/decode/execute controller for the accumulator CPU: owns PC/IR/MBR/AC
// and drives sync-RAM controls and ALU operands with registered outputs.
module acc_cpu_controller import cpu_pkg::*; #(
  parameter int                    ADDR_WIDTH = 28,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 'h100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           alu_left,
  output logic [31:0]           alu_right,
  output logic [3:0]            alu_ctrl,
  input  logic [31:0]           alu_out,
  output logic                  busy,
  output logic                  halted,
  output logic                  illegal,
  output logic [ADDR_WIDTH-1:0] pc_dbg,
  output logic [DATA_WIDTH-1:0] ac_dbg
);

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] pc, pc_n;
  logic [DATA_WIDTH-1:0] ir, mbr, ac;
  logic [3:0]            op;

  iclass_t               iclass;
  logic                  skip_taken, dec_illegal;
  logic [DATA_WIDTH-1:0] imm_sext;

  ctrl_decode #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .ir        (ir),
    .ac        (ac),
    .iclass    (iclass),
    .skip_taken(skip_taken),
    .imm_sext  (imm_sext),
    .illegal   (dec_illegal)
  );

  assign op        = ir[DATA_WIDTH-1 -: 4];
  assign alu_left  = ac;
  assign alu_right = (op == OP_ADDI) ? imm_sext : mbr;
  assign alu_ctrl  = ALU_ADD;
  assign pc_dbg    = pc;
  assign ac_dbg    = ac;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    case (state)
      IDLE, HALTED: if (start) begin
        state_n = F0;
        pc_n    = RESET_PC;
      end
      F0: state_n = F1;
      F1: state_n = F2;
      F2: begin
        state_n = D;
        pc_n    = pc + 1'b1;
      end
      D: begin
        state_n = F0;
        case (iclass)
          CL_MEM:   state_n = M0;
          CL_STORE: state_n = S0;
          CL_ADDI:  state_n = X;
          CL_HALT:  state_n = HALTED;
          CL_JUMP:  pc_n = ir[ADDR_WIDTH-1:0];
          CL_SKIP:  if (skip_taken) pc_n = pc + 1'b1;
          default:  state_n = F0;
        endcase
      end
      M0: state_n = M1;
      M1: state_n = M2;
      M2: state_n = (op == OP_ADD) ? X : F0;
      X:  state_n = F0;
      S0: state_n = F0;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      ir        <= '0;
      mbr       <= '0;
      ac        <= '0;
      mem_addr  <= '0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      busy   <= !(state_n inside {IDLE, HALTED});
      halted <= (state_n == HALTED);

      if (state == F2) ir <= mem_rdata;
      if (state == M2) begin
        if (op == OP_ADD) mbr <= mem_rdata;
        else              ac  <= mem_rdata;
      end
      if (state == D && iclass == CL_CLEAR) ac <= '0;
      if (state == X) ac <= alu_out;

      if ((state == IDLE || state == HALTED) && start) illegal <= 1'b0;
      else if (state == D && dec_illegal)              illegal <= 1'b1;

      // Controls are set for the state being entered so they are valid
      // for the whole of that state.
      mem_cs <= 1'b0;
      mem_we <= 1'b0;
      mem_oe <= 1'b0;
      case (state_n)
        F0: begin
          mem_addr <= pc_n;
          mem_cs   <= 1'b1;
          mem_oe   <= 1'b1;
        end
        F1, M1: begin
          mem_cs <= 1'b1;
          mem_oe <= 1'b1;
        end
        M0: begin
          mem_addr <= ir[ADDR_WIDTH-1:0];
          mem_cs   <= 1'b1;
          mem_oe   <= 1'b1;
        end
        S0: begin
          mem_addr  <= ir[ADDR_WIDTH-1:0];
          mem_wdata <= ac;
          mem_cs    <= 1'b1;
          mem_we    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_cpu_controller.sv
// Directed bench: RAM/ALU models around the controller, hand-computed results.
module tb_acc_cpu_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [27:0] mem_addr;
  logic        mem_cs, mem_we, mem_oe;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [31:0] alu_left, alu_right, alu_out;
  logic [3:0]  alu_ctrl;
  logic        busy, halted, illegal;
  logic [27:0] pc_dbg;
  logic [31:0] ac_dbg;

  logic [31:0] mem [0:1023];
  logic        ld_en = 1'b0;
  int          ld_addr = 0;
  logic [31:0] ld_data = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  acc_cpu_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .alu_left(alu_left), .alu_right(alu_right), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .busy(busy), .halted(halted), .illegal(illegal),
    .pc_dbg(pc_dbg), .ac_dbg(ac_dbg)
  );

  assign alu_out = (alu_ctrl == 4'b0010) ? alu_left + alu_right : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_cs && mem_we) mem[int'(mem_addr & 28'h3FF)] <= mem_wdata;
    if (mem_cs && mem_oe && !mem_we) mem_rdata <= mem[int'(mem_addr & 28'h3FF)];
  end

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic prog4(input logic [31:0] w0, w1, w2, w3);
    poke('h100, w0); poke('h101, w1); poke('h102, w2); poke('h103, w3);
  endtask

  task automatic do_reset();
    @(negedge clk) rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run(input int max, output int cyc);
    start_pulse();
    cyc = 0;
    while (!halted && cyc < max) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({mem_addr, mem_cs, mem_we, mem_oe, mem_wdata, busy, halted, illegal} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got addr=%h cs=%b we=%b oe=%b wd=%h busy=%b halt=%b ill=%b, want all 0",
        mem_addr, mem_cs, mem_we, mem_oe, mem_wdata, busy, halted, illegal);
    end
    n_tests++;
    if (pc_dbg !== 28'h100 || ac_dbg !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs: got pc=%h ac=%h, want pc=100 ac=0", pc_dbg, ac_dbg);
    end
    prog4(32'h2000_0110, 32'h0000_0111, 32'h3000_0112, 32'h1000_0000);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0 || mem_cs !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b cs=%b, want 0 0", busy, mem_cs);
    end
    start_pulse();
    n_tests++;
    if (mem_addr !== 28'h100 || mem_cs !== 1'b1 || mem_oe !== 1'b1 || mem_we !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL first_fetch: got addr=%h cs=%b oe=%b we=%b busy=%b, want 100 1 1 0 1",
        mem_addr, mem_cs, mem_oe, mem_we, busy);
    end
  endtask

  task automatic test_arith();
    int cyc;
    do_reset();
    poke('h110, 32'd5); poke('h111, 32'd7); poke('h112, 32'd0);
    run(100, cyc);
    n_tests++;
    if (cyc !== 24) begin n_fail++; $display("FAIL arith_cycles: got %0d, want 24", cyc); end
    n_tests++;
    if (mem['h112] !== 32'd12 || ac_dbg !== 32'd12) begin
      n_fail++; $display("FAIL arith_result: got mem=%0d ac=%0d, want 12 12", mem['h112], ac_dbg);
    end
    n_tests++;
    if (pc_dbg !== 28'h104 || halted !== 1'b1 || busy !== 1'b0 || alu_ctrl !== 4'b0010) begin
      n_fail++; $display("FAIL arith_halt: got pc=%h halted=%b busy=%b ctrl=%b, want 104 1 0 0010",
        pc_dbg, halted, busy, alu_ctrl);
    end
  endtask

  task automatic test_addi();
    int cyc;
    prog4(32'h4000_0000, 32'h7FF0_0000, 32'h1000_0000, 32'h1000_0000);
    run(100, cyc);
    n_tests++;
    if (ac_dbg !== 32'hFFFF_FFFF || cyc !== 13) begin
      n_fail++; $display("FAIL addi_neg: got ac=%h cyc=%0d, want ffffffff 13", ac_dbg, cyc);
    end
    prog4(32'h7010_0000, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000);
    run(100, cyc);
    n_tests++;
    if (ac_dbg !== 32'h0 || cyc !== 9 || pc_dbg !== 28'h102) begin
      n_fail++; $display("FAIL addi_wrap: got ac=%h cyc=%0d pc=%h, want 0 9 102", ac_dbg, cyc, pc_dbg);
    end
  endtask

  task automatic test_skip();
    int cyc;
    // AC is 0 here; a missed skip would spin on the JUMP and time out
    prog4(32'h5000_0002, 32'h6000_0100, 32'h1000_0000, 32'h1000_0000);
    run(60, cyc);
    n_tests++;
    if (pc_dbg !== 28'h103 || cyc !== 8) begin
      n_fail++; $display("FAIL skip_zero: got pc=%h cyc=%0d, want 103 8", pc_dbg, cyc);
    end
    prog4(32'h2000_0110, 32'h5000_0000, 32'h1000_0000, 32'h1000_0000);
    run(100, cyc);
    n_tests++;
    if (pc_dbg !== 28'h103 || cyc !== 15) begin
      n_fail++; $display("FAIL skip_neg_not_taken: got pc=%h cyc=%0d, want 103 15", pc_dbg, cyc);
    end
    prog4(32'h2000_0110, 32'h5000_0004, 32'h1000_0000, 32'h1000_0000);
    run(100, cyc);
    n_tests++;
    if (pc_dbg !== 28'h104) begin
      n_fail++; $display("FAIL skip_pos: got pc=%h, want 104", pc_dbg);
    end
    poke('h113, 32'h8000_0000);
    prog4(32'h2000_0113, 32'h5000_0000, 32'h1000_0000, 32'h1000_0000);
    run(100, cyc);
    n_tests++;
    if (pc_dbg !== 28'h104 || ac_dbg !== 32'h8000_0000) begin
      n_fail++; $display("FAIL skip_neg_taken: got pc=%h ac=%h, want 104 80000000", pc_dbg, ac_dbg);
    end
  endtask

  task automatic test_jump_illegal();
    int cyc;
    prog4(32'h9000_0000, 32'h6000_0105, 32'h1000_0000, 32'h1000_0000);
    poke('h105, 32'h1000_0000);
    run(100, cyc);
    n_tests++;
    if (illegal !== 1'b1 || ac_dbg !== 32'h8000_0000 || pc_dbg !== 28'h106 || cyc !== 12) begin
      n_fail++; $display("FAIL illegal_nop: got ill=%b ac=%h pc=%h cyc=%0d, want 1 80000000 106 12",
        illegal, ac_dbg, pc_dbg, cyc);
    end
    prog4(32'h6000_0100, 32'h1000_0000, 32'h1000_0000, 32'h1000_0000);
    start_pulse();
    n_tests++;
    if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_clear: got %b, want 0", illegal); end
    repeat (20) @(posedge clk);
    #1;
    n_tests++;
    if (halted !== 1'b0 || busy !== 1'b1 || pc_dbg > 28'h101) begin
      n_fail++; $display("FAIL jump_loop: got halted=%b busy=%b pc=%h, want 0 1 <=101", halted, busy, pc_dbg);
    end
  endtask

  task automatic test_midrun_reset();
    int cyc;
    do_reset();
    prog4(32'h2000_0110, 32'h0000_0111, 32'h3000_0112, 32'h1000_0000);
    poke('h112, 32'd0);
    start_pulse();
    repeat (12) @(posedge clk);
    #1;
    n_tests++;
    if (mem_addr !== 28'h111 || mem_cs !== 1'b1 || mem_oe !== 1'b1 || ac_dbg !== 32'd5) begin
      n_fail++; $display("FAIL add_m1: got addr=%h cs=%b oe=%b ac=%0d, want 111 1 1 5", mem_addr, mem_cs, mem_oe, ac_dbg);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (mem_cs !== 1'b0 || mem_we !== 1'b0 || mem_oe !== 1'b0 || ac_dbg !== 32'h0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset: got cs=%b we=%b oe=%b ac=%h busy=%b, want 0 0 0 0 0",
        mem_cs, mem_we, mem_oe, ac_dbg, busy);
    end
    @(negedge clk) rst_n = 1'b1;
    run(100, cyc);
    n_tests++;
    if (cyc !== 24 || mem['h112] !== 32'd12 || pc_dbg !== 28'h104) begin
      n_fail++; $display("FAIL rerun_after_reset: got cyc=%0d mem=%0d pc=%h, want 24 12 104", cyc, mem['h112], pc_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_addi();
    test_skip();
    test_jump_illegal();
    test_midrun_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
